// File: rtl/timestamp_reader.sv
`timescale 1ns/1ps
// timestamp_reader
// Reads captured timestamps out of the capture-and-serialise timestamper.
// Waits for the (synchronised) INT flag, clocks the captured word in over
// SPI (MSB first), pulses RSTCAPT to re-arm the timestamper, and holds the
// word in a one-entry valid/ready output register for the host.
//
// Ports
//   CLK       system clock, rising edge
//   RST       asynchronous active-high reset
//   INT       timestamper capture flag (asynchronous, synchronised here)
//   SDO       serial data from the timestamper
//   SCLK      SPI clock, idles low
//   CE_N      SPI chip enable, active low
//   RSTCAPT   re-arm pulse to the timestamper, SCLK_DIV cycles wide
//   TS_DATA   last timestamp read
//   TS_VALID  TS_DATA holds an unconsumed word
//   TS_READY  host accepts TS_DATA when TS_VALID & TS_READY
//   BUSY      high in every state except IDLE
module timestamp_reader #(
  parameter int WIDTH    = 4,
  parameter int SCLK_DIV = 2
) (
  input  logic             CLK,
  input  logic             RST,
  input  logic             INT,
  input  logic             SDO,
  output logic             SCLK,
  output logic             CE_N,
  output logic             RSTCAPT,
  output logic [WIDTH-1:0] TS_DATA,
  output logic             TS_VALID,
  input  logic             TS_READY,
  output logic             BUSY
);

  localparam int DW = (SCLK_DIV > 1) ? $clog2(SCLK_DIV) : 1;
  localparam int BW = $clog2(WIDTH + 1);
  localparam logic [DW-1:0] DIV_LAST = DW'(SCLK_DIV - 1);
  localparam logic [BW-1:0] BIT_ALL  = BW'(WIDTH);

  typedef enum logic [2:0] {
    S_INIT, S_IDLE, S_SETUP, S_SHI, S_SLO, S_REARM, S_WAITCLR
  } state_e;

  state_e           state_q, state_d;
  logic [DW-1:0]    div_q, div_d;
  logic [BW-1:0]    bit_q, bit_d;
  logic [WIDTH-1:0] shift_q, shift_d;
  logic [WIDTH-1:0] data_q, data_d;
  logic             valid_q, valid_d;
  logic             sclk_q, sclk_d;
  logic             ce_n_q, ce_n_d;
  logic             rc_q, rc_d;
  logic             int_meta_q, int_s_q;
  logic             div_done;

  assign div_done = (div_q == DIV_LAST);

  // Two-flop synchroniser for the asynchronous INT flag.
  always_ff @(posedge CLK or posedge RST) begin
    if (RST) begin
      int_meta_q <= 1'b0;
      int_s_q    <= 1'b0;
    end else begin
      int_meta_q <= INT;
      int_s_q    <= int_meta_q;
    end
  end

  always_ff @(posedge CLK or posedge RST) begin
    if (RST) begin
      state_q <= S_INIT;
      div_q   <= '0;
      bit_q   <= '0;
      shift_q <= '0;
      data_q  <= '0;
      valid_q <= 1'b0;
      sclk_q  <= 1'b0;
      ce_n_q  <= 1'b1;
      rc_q    <= 1'b0;
    end else begin
      state_q <= state_d;
      div_q   <= div_d;
      bit_q   <= bit_d;
      shift_q <= shift_d;
      data_q  <= data_d;
      valid_q <= valid_d;
      sclk_q  <= sclk_d;
      ce_n_q  <= ce_n_d;
      rc_q    <= rc_d;
    end
  end

  always_comb begin
    state_d = state_q;
    div_d   = div_q;
    bit_d   = bit_q;
    shift_d = shift_q;
    data_d  = data_q;
    valid_d = valid_q & ~TS_READY;   // host consumption; a load below overrides
    sclk_d  = sclk_q;
    ce_n_d  = ce_n_q;
    rc_d    = rc_q;

    unique case (state_q)
      // INIT is entered from reset with RSTCAPT low, so its first cycle only
      // raises RSTCAPT; after that it shares REARM's pulse-width count.
      S_INIT, S_REARM: begin
        if (!rc_q) begin
          rc_d  = 1'b1;
          div_d = '0;
        end else if (div_done) begin
          rc_d    = 1'b0;
          div_d   = '0;
          state_d = S_WAITCLR;
        end else begin
          div_d = div_q + DW'(1);
        end
      end

      // The synchronised flag lags the pin, so wait until it has really
      // dropped before looking for the next capture.
      S_WAITCLR: begin
        if (!int_s_q) state_d = S_IDLE;
      end

      S_IDLE: begin
        if (int_s_q && (!valid_q || TS_READY)) begin
          state_d = S_SETUP;
          ce_n_d  = 1'b0;
          div_d   = '0;
          bit_d   = '0;
        end
      end

      // SDO is captured on the edge that raises SCLK, i.e. while it still
      // holds the value presented during the preceding low phase.
      S_SETUP: begin
        if (div_done) begin
          state_d = S_SHI;
          sclk_d  = 1'b1;
          div_d   = '0;
          shift_d = (shift_q << 1) | WIDTH'(SDO);
          bit_d   = bit_q + BW'(1);
        end else begin
          div_d = div_q + DW'(1);
        end
      end

      S_SHI: begin
        if (div_done) begin
          state_d = S_SLO;
          sclk_d  = 1'b0;
          div_d   = '0;
        end else begin
          div_d = div_q + DW'(1);
        end
      end

      S_SLO: begin
        if (div_done) begin
          div_d = '0;
          if (bit_q < BIT_ALL) begin
            state_d = S_SHI;
            sclk_d  = 1'b1;
            shift_d = (shift_q << 1) | WIDTH'(SDO);
            bit_d   = bit_q + BW'(1);
          end else begin
            // CE_N release, word load and re-arm all happen on this edge.
            state_d = S_REARM;
            ce_n_d  = 1'b1;
            data_d  = shift_q;
            valid_d = 1'b1;
            rc_d    = 1'b1;
          end
        end else begin
          div_d = div_q + DW'(1);
        end
      end

      default: state_d = S_INIT;
    endcase
  end

  assign SCLK     = sclk_q;
  assign CE_N     = ce_n_q;
  assign RSTCAPT  = rc_q;
  assign TS_DATA  = data_q;
  assign TS_VALID = valid_q;
  assign BUSY     = (state_q != S_IDLE);

endmodule

// File: tb/tb_timestamp_reader.sv
`timescale 1ns/1ps
module tb_timestamp_reader;

  localparam int DIV_A = 2;
  localparam int DIV_B = 1;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  int n_chk  = 0;
  int n_fail = 0;

  // ---------------- DUT A: WIDTH=4, SCLK_DIV=2 ----------------
  logic       rst_a, sdo_a, sclk_a, ce_n_a, rstcapt_a, ts_valid_a, ts_ready_a, busy_a;
  logic       int_a = 1'b0;
  logic [3:0] ts_data_a;

  timestamp_reader #(.WIDTH(4), .SCLK_DIV(DIV_A)) u_dut_a (
    .CLK(clk), .RST(rst_a), .INT(int_a), .SDO(sdo_a), .SCLK(sclk_a), .CE_N(ce_n_a),
    .RSTCAPT(rstcapt_a), .TS_DATA(ts_data_a), .TS_VALID(ts_valid_a),
    .TS_READY(ts_ready_a), .BUSY(busy_a));

  // ---------------- DUT B: WIDTH=8, SCLK_DIV=1 ----------------
  logic       rst_b, sdo_b, sclk_b, ce_n_b, rstcapt_b, ts_valid_b, ts_ready_b, busy_b;
  logic       int_b = 1'b0;
  logic [7:0] ts_data_b;

  timestamp_reader #(.WIDTH(8), .SCLK_DIV(DIV_B)) u_dut_b (
    .CLK(clk), .RST(rst_b), .INT(int_b), .SDO(sdo_b), .SCLK(sclk_b), .CE_N(ce_n_b),
    .RSTCAPT(rstcapt_b), .TS_DATA(ts_data_b), .TS_VALID(ts_valid_b),
    .TS_READY(ts_ready_b), .BUSY(busy_b));

  // ---------------- timestamper models ----------------
  // A capture event waits in wq_* until the timestamper is armed; then the
  // word is latched and INT raised. RSTCAPT drops INT. The word is shifted out
  // MSB first: presented when CE_N falls, next bit after each SCLK rise.
  logic [3:0] wq_a[$], exp_a[$];
  logic [7:0] wq_b[$], exp_b[$];
  logic [3:0] word_a = '0, sr_a = '0;
  logic [7:0] word_b = '0, sr_b = '0;

  always @(posedge clk)
    if (rstcapt_a) int_a <= 1'b0;
    else if (!int_a && wq_a.size() != 0) begin word_a <= wq_a.pop_front(); int_a <= 1'b1; end

  always @(posedge clk)
    if (rstcapt_b) int_b <= 1'b0;
    else if (!int_b && wq_b.size() != 0) begin word_b <= wq_b.pop_front(); int_b <= 1'b1; end

  always @(negedge ce_n_a or posedge sclk_a) sr_a <= sclk_a ? (sr_a << 1) : word_a;
  always @(negedge ce_n_b or posedge sclk_b) sr_b <= sclk_b ? (sr_b << 1) : word_b;
  assign sdo_a = sr_a[3];
  assign sdo_b = sr_b[7];

  // ---------------- monitor + scoreboard A ----------------
  int         ce_cnt_a = 0, rise_a = 0, per_a = 0, rc_cnt_a = 0;
  logic       ce_q_a = 1'b1, sclk_q_a = 1'b0, rc_q_a = 1'b0, abort_a = 1'b1;
  logic       v_q_a = 1'b0, acc_q_a = 1'b0;
  logic [3:0] d_q_a = '0, e_a;

  always @(negedge clk) begin
    if (rst_a) abort_a = 1'b1;
    if (!ce_n_a) begin
      if (ce_q_a) begin ce_cnt_a = 0; rise_a = 0; per_a = 0; abort_a = 1'b0; end
      ce_cnt_a++; per_a++;
      if (sclk_a && !sclk_q_a) begin
        rise_a++;
        if (rise_a > 1) begin
          n_chk++;
          if (per_a != 2*DIV_A) begin n_fail++; $display("FAIL a_sclk_period: got %0d want %0d", per_a, 2*DIV_A); end
        end
        per_a = 0;
      end
    end
    if (ce_n_a && !ce_q_a && !abort_a) begin
      n_chk++;
      if (ce_cnt_a != DIV_A*9) begin n_fail++; $display("FAIL a_ce_low: got %0d want %0d", ce_cnt_a, DIV_A*9); end
      n_chk++;
      if (rise_a != 4) begin n_fail++; $display("FAIL a_sclk_rises: got %0d want 4", rise_a); end
      n_chk++;
      if (!ts_valid_a || !rstcapt_a) begin n_fail++; $display("FAIL a_ce_rise_align: valid=%b rstcapt=%b want 1 1", ts_valid_a, rstcapt_a); end
    end
    n_chk++;
    if (sclk_a && ce_n_a) begin n_fail++; $display("FAIL a_sclk_glitch: sclk=1 with ce_n=1"); end
    if (rstcapt_a) rc_cnt_a++;
    else if (rc_q_a) begin
      n_chk++;
      if (rc_cnt_a != DIV_A) begin n_fail++; $display("FAIL a_rstcapt_width: got %0d want %0d", rc_cnt_a, DIV_A); end
      rc_cnt_a = 0;
    end
    if (ts_valid_a && ts_ready_a) begin
      n_chk++;
      if (exp_a.size() == 0) begin n_fail++; $display("FAIL a_unexpected_word: got %h want none", ts_data_a); end
      else begin
        e_a = exp_a.pop_front();
        if (ts_data_a !== e_a) begin n_fail++; $display("FAIL a_word: got %h want %h", ts_data_a, e_a); end
      end
    end
    if (v_q_a && !acc_q_a && ts_valid_a) begin
      n_chk++;
      if (ts_data_a !== d_q_a) begin n_fail++; $display("FAIL a_data_stable: got %h want %h", ts_data_a, d_q_a); end
    end
    ce_q_a = ce_n_a; sclk_q_a = sclk_a; rc_q_a = rstcapt_a;
    v_q_a = ts_valid_a; acc_q_a = ts_valid_a & ts_ready_a; d_q_a = ts_data_a;
  end

  // ---------------- monitor + scoreboard B ----------------
  int         ce_cnt_b = 0, rise_b = 0, per_b = 0, rc_cnt_b = 0;
  logic       ce_q_b = 1'b1, sclk_q_b = 1'b0, rc_q_b = 1'b0;
  logic [7:0] e_b;

  always @(negedge clk) begin
    if (!ce_n_b) begin
      if (ce_q_b) begin ce_cnt_b = 0; rise_b = 0; per_b = 0; end
      ce_cnt_b++; per_b++;
      if (sclk_b && !sclk_q_b) begin
        rise_b++;
        if (rise_b > 1) begin
          n_chk++;
          if (per_b != 2*DIV_B) begin n_fail++; $display("FAIL b_sclk_period: got %0d want %0d", per_b, 2*DIV_B); end
        end
        per_b = 0;
      end
    end
    if (ce_n_b && !ce_q_b) begin
      n_chk++;
      if (ce_cnt_b != DIV_B*17) begin n_fail++; $display("FAIL b_ce_low: got %0d want %0d", ce_cnt_b, DIV_B*17); end
      n_chk++;
      if (rise_b != 8) begin n_fail++; $display("FAIL b_sclk_rises: got %0d want 8", rise_b); end
    end
    n_chk++;
    if (sclk_b && ce_n_b) begin n_fail++; $display("FAIL b_sclk_glitch: sclk=1 with ce_n=1"); end
    if (rstcapt_b) rc_cnt_b++;
    else if (rc_q_b) begin
      n_chk++;
      if (rc_cnt_b != DIV_B) begin n_fail++; $display("FAIL b_rstcapt_width: got %0d want %0d", rc_cnt_b, DIV_B); end
      rc_cnt_b = 0;
    end
    if (ts_valid_b && ts_ready_b) begin
      n_chk++;
      if (exp_b.size() == 0) begin n_fail++; $display("FAIL b_unexpected_word: got %h want none", ts_data_b); end
      else begin
        e_b = exp_b.pop_front();
        if (ts_data_b !== e_b) begin n_fail++; $display("FAIL b_word: got %h want %h", ts_data_b, e_b); end
      end
    end
    ce_q_b = ce_n_b; sclk_q_b = sclk_b; rc_q_b = rstcapt_b;
  end

  // Bounded wait until DUT A has drained everything and is back in IDLE.
  task automatic wait_done_a(input int max, output bit ok);
    ok = 1'b0;
    for (int i = 0; i < max && !ok; i++) begin
      @(negedge clk);
      ok = !busy_a && !int_a && wq_a.size() == 0 && exp_a.size() == 0;
    end
  endtask

  // ---------------- scenarios ----------------
  task automatic test_reset();
    int rc, ce_low, sk;
    repeat (3) @(negedge clk);
    n_chk++; if (ce_n_a !== 1'b1)    begin n_fail++; $display("FAIL rst_ce_n: got %b want 1", ce_n_a); end
    n_chk++; if (sclk_a !== 1'b0)    begin n_fail++; $display("FAIL rst_sclk: got %b want 0", sclk_a); end
    n_chk++; if (rstcapt_a !== 1'b0) begin n_fail++; $display("FAIL rst_rstcapt: got %b want 0", rstcapt_a); end
    n_chk++; if (ts_valid_a !== 1'b0) begin n_fail++; $display("FAIL rst_valid: got %b want 0", ts_valid_a); end
    n_chk++; if (ts_data_a !== 4'h0) begin n_fail++; $display("FAIL rst_data: got %h want 0", ts_data_a); end
    n_chk++; if (busy_a !== 1'b1)    begin n_fail++; $display("FAIL rst_busy: got %b want 1", busy_a); end
    n_chk++; if (busy_b !== 1'b1)    begin n_fail++; $display("FAIL rst_busy_b: got %b want 1", busy_b); end
    @(posedge clk); #1; rst_a = 1'b0; rst_b = 1'b0;
    rc = 0; ce_low = 0; sk = 0;
    repeat (6) begin
      @(negedge clk);
      if (rstcapt_a) rc++;
      if (!ce_n_a) ce_low++;
      if (sclk_a) sk++;
    end
    n_chk++; if (rc != DIV_A)  begin n_fail++; $display("FAIL init_rstcapt_cycles: got %0d want %0d", rc, DIV_A); end
    n_chk++; if (ce_low != 0)  begin n_fail++; $display("FAIL init_ce_n: got %0d low cycles want 0", ce_low); end
    n_chk++; if (sk != 0)      begin n_fail++; $display("FAIL init_sclk: got %0d high cycles want 0", sk); end
    n_chk++; if (busy_a !== 1'b0) begin n_fail++; $display("FAIL init_idle_busy: got %b want 0", busy_a); end
  endtask

  task automatic test_single();
    int cnt, vcnt;
    bit ok;
    @(posedge clk); #1;
    ts_ready_a = 1'b1;
    wq_a.push_back(4'hA); exp_a.push_back(4'hA);
    cnt = 0;
    do begin @(negedge clk); cnt++; end while (!int_a && cnt < 10);
    cnt = 0;
    do begin @(negedge clk); cnt++; end while (ce_n_a && cnt < 10);
    n_chk++; if (cnt != 3) begin n_fail++; $display("FAIL int_to_ce_n: got %0d edges want 3", cnt); end
    vcnt = 0; ok = 1'b0;
    for (int i = 0; i < 100 && !ok; i++) begin
      @(negedge clk);
      if (ts_valid_a) vcnt++;
      ok = !busy_a && !int_a && wq_a.size() == 0 && exp_a.size() == 0;
    end
    n_chk++; if (!ok) begin n_fail++; $display("FAIL single_done: timeout waiting for read/rearm"); end
    n_chk++; if (vcnt != 1) begin n_fail++; $display("FAIL single_valid_cycles: got %0d want 1", vcnt); end
    n_chk++; if (ts_data_a !== 4'hA) begin n_fail++; $display("FAIL single_data: got %h want a", ts_data_a); end
  endtask

  task automatic test_backpressure();
    int falls;
    bit ok;
    logic cp;
    @(posedge clk); #1;
    ts_ready_a = 1'b0;
    wq_a.push_back(4'h3); exp_a.push_back(4'h3);
    wq_a.push_back(4'hC); exp_a.push_back(4'hC);
    falls = 0; cp = ce_n_a;
    repeat (80) begin
      @(negedge clk);
      if (!ce_n_a && cp) falls++;
      cp = ce_n_a;
    end
    n_chk++; if (falls != 1) begin n_fail++; $display("FAIL bp_reads_while_full: got %0d want 1", falls); end
    n_chk++; if (ts_valid_a !== 1'b1) begin n_fail++; $display("FAIL bp_valid_held: got %b want 1", ts_valid_a); end
    n_chk++; if (ts_data_a !== 4'h3) begin n_fail++; $display("FAIL bp_data_held: got %h want 3", ts_data_a); end
    n_chk++; if (int_a !== 1'b1) begin n_fail++; $display("FAIL bp_int_held: got %b want 1", int_a); end
    n_chk++; if (ce_n_a !== 1'b1 || busy_a !== 1'b0) begin n_fail++; $display("FAIL bp_waiting_idle: ce_n=%b busy=%b want 1 0", ce_n_a, busy_a); end
    @(posedge clk); #1;
    ts_ready_a = 1'b1;
    wait_done_a(100, ok);
    n_chk++; if (!ok) begin n_fail++; $display("FAIL bp_drain: timeout, %0d words outstanding", exp_a.size()); end
    n_chk++; if (ts_data_a !== 4'hC) begin n_fail++; $display("FAIL bp_second_word: got %h want c", ts_data_a); end
  endtask

  task automatic test_back_to_back();
    int falls, rcr;
    bit ok;
    logic cp, rp;
    @(posedge clk); #1;
    ts_ready_a = 1'b1;
    wq_a.push_back(4'hF); exp_a.push_back(4'hF);
    wq_a.push_back(4'h0); exp_a.push_back(4'h0);
    wq_a.push_back(4'h5); exp_a.push_back(4'h5);
    falls = 0; rcr = 0; cp = ce_n_a; rp = rstcapt_a; ok = 1'b0;
    for (int i = 0; i < 300 && !ok; i++) begin
      @(negedge clk);
      if (!ce_n_a && cp) falls++;
      if (rstcapt_a && !rp) rcr++;
      cp = ce_n_a; rp = rstcapt_a;
      ok = !busy_a && !int_a && wq_a.size() == 0 && exp_a.size() == 0;
    end
    n_chk++; if (!ok) begin n_fail++; $display("FAIL b2b_done: timeout"); end
    n_chk++; if (falls != 3) begin n_fail++; $display("FAIL b2b_reads: got %0d want 3", falls); end
    n_chk++; if (rcr != 3) begin n_fail++; $display("FAIL b2b_rstcapt_pulses: got %0d want 3", rcr); end
    n_chk++; if (ts_data_a !== 4'h5) begin n_fail++; $display("FAIL b2b_last: got %h want 5", ts_data_a); end
  endtask

  task automatic test_reset_mid();
    int rises, rc;
    bit ok;
    logic sp;
    @(posedge clk); #1;
    ts_ready_a = 1'b1;
    wq_a.push_back(4'h9); exp_a.push_back(4'h9);
    rises = 0; sp = sclk_a;
    for (int i = 0; i < 100 && rises < 2; i++) begin
      @(negedge clk);
      if (sclk_a && !sp) rises++;
      sp = sclk_a;
    end
    n_chk++; if (rises != 2) begin n_fail++; $display("FAIL mid_sclk_wait: got %0d rises want 2", rises); end
    #2; rst_a = 1'b1;
    #1;
    n_chk++;
    if (ce_n_a !== 1'b1 || sclk_a !== 1'b0 || ts_valid_a !== 1'b0 || ts_data_a !== 4'h0) begin
      n_fail++;
      $display("FAIL mid_async_reset: ce_n=%b sclk=%b valid=%b data=%h want 1 0 0 0", ce_n_a, sclk_a, ts_valid_a, ts_data_a);
    end
    void'(exp_a.pop_front());   // the interrupted word is never delivered
    @(posedge clk); @(posedge clk); #1;
    rst_a = 1'b0;
    rc = 0;
    repeat (8) begin @(negedge clk); if (rstcapt_a) rc++; end
    n_chk++; if (rc != DIV_A) begin n_fail++; $display("FAIL mid_init_rstcapt: got %0d want %0d", rc, DIV_A); end
    @(posedge clk); #1;
    wq_a.push_back(4'h7); exp_a.push_back(4'h7);
    wait_done_a(100, ok);
    n_chk++; if (!ok) begin n_fail++; $display("FAIL mid_next_read: timeout"); end
    n_chk++; if (ts_data_a !== 4'h7) begin n_fail++; $display("FAIL mid_next_data: got %h want 7", ts_data_a); end
  endtask

  task automatic test_wide();
    bit ok;
    @(posedge clk); #1;
    wq_b.push_back(8'h96); exp_b.push_back(8'h96);
    ok = 1'b0;
    for (int i = 0; i < 200 && !ok; i++) begin
      @(negedge clk);
      ok = !busy_b && !int_b && wq_b.size() == 0 && exp_b.size() == 0;
    end
    n_chk++; if (!ok) begin n_fail++; $display("FAIL wide_done: timeout"); end
    n_chk++; if (ts_data_b !== 8'h96) begin n_fail++; $display("FAIL wide_data: got %h want 96", ts_data_b); end
  endtask

  initial begin
    rst_a = 1'b1; rst_b = 1'b1;
    ts_ready_a = 1'b0; ts_ready_b = 1'b1;
    test_reset();
    test_single();
    test_backpressure();
    test_back_to_back();
    test_reset_mid();
    test_wide();
    repeat (4) @(negedge clk);
    $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL watchdog: simulation did not finish in time");
    $fatal(1);
  end

endmodule

// File: doc/timestamp_reader.md
# timestamp_reader

Downstream consumer of the capture-and-serialise timestamper. Watches the timestamper's INT flag, runs the SPI read of the captured count (CE_N/SCLK/SDO, MSB first), pulses RSTCAPT to re-arm capture, and presents each timestamp to the host logic through a one-entry valid/ready output register. Runs entirely on the system clock CLK.

## Interface
- WIDTH, 4: timestamp width in bits (>=1); also the SCLK pulses per read.
- SCLK_DIV, 2: CLK cycles per SCLK half-period (>=1); also the CE_N setup time and the RSTCAPT pulse width.
- CLK  in  1  system clock; all logic on the rising edge.
- RST  in  1  asynchronous, active-high reset.
- INT  in  1  timestamper capture flag (high = word captured); asynchronous, 2-flop synchronised to INT_s.
- SDO  in  1  serial data from the timestamper, MSB first.
- SCLK  out  1  SPI clock, idles low.
- CE_N  out  1  SPI chip enable, active low.
- RSTCAPT  out  1  re-arm pulse to the timestamper.
- TS_DATA  out  WIDTH  last timestamp read.
- TS_VALID  out  1  TS_DATA holds an unconsumed word.
- TS_READY  in  1  host accepts TS_DATA when TS_VALID & TS_READY.
- BUSY  out  1  high in every state except IDLE.

## Operation
- Reset values: SCLK=0, CE_N=1, RSTCAPT=0, TS_DATA=0, TS_VALID=0, BUSY=1 (state INIT), shift register and counters 0, INT sync flops 0.
- States: INIT, IDLE, SETUP, SHI, SLO, REARM, WAITCLR.
- INIT: RSTCAPT=1 for SCLK_DIV cycles, then WAITCLR. Every reset, including mid-transfer, re-arms the timestamper this way.
- IDLE: go to SETUP when INT_s=1 and the output register is free. Free means TS_VALID=0, or TS_VALID & TS_READY in the same cycle.
- While the output register is full, the reader waits and INT stays high. The timestamper keeps its word and ignores further captures. This is the required behaviour, not an error.
- SETUP: CE_N=0, SCLK=0 for SCLK_DIV cycles, then SHI.
- SHI: SCLK=1 for SCLK_DIV cycles.
  - On the edge entering SHI, SDO shifts into the LSB of the shift register (shift left). SDO is sampled while it is still stable from the low phase.
  - Bit counter increments on that edge.
- SLO: SCLK=0 for SCLK_DIV cycles.
  - If bit counter < WIDTH, go to SHI.
  - Otherwise, on the exiting edge: CE_N=1, TS_DATA=shift register, TS_VALID=1, RSTCAPT=1, go to REARM.
- REARM: RSTCAPT held for SCLK_DIV cycles total, then RSTCAPT=0 and WAITCLR.
- WAITCLR: stay until INT_s=0, then IDLE. This prevents re-reading a stale flag through the synchroniser delay.
- TS_VALID clears on TS_VALID & TS_READY, except on the same edge a new word loads; then it stays 1 with the new data.
- INT is ignored outside IDLE and WAITCLR.
- SDO is only sampled at SHI entry.
- Counters use $clog2 widths. The bit counter must hold the value WIDTH.

## Timing
- INT pin rise to CE_N fall: 3 CLK edges (2 sync + 1 IDLE->SETUP), given a free output register.
- CE_N low duration: SCLK_DIV*(2*WIDTH+1) cycles. This is 18 at defaults.
- SCLK period: 2*SCLK_DIV cycles; exactly WIDTH rising edges per read.
- CE_N rise, TS_VALID rise and RSTCAPT rise occur on the same edge.
- RSTCAPT width: exactly SCLK_DIV cycles.
- TS_DATA is stable whenever TS_VALID=1 and changes only on a load.
- Minimum read-to-read spacing: SETUP + shift + REARM + 1 WAITCLR cycle after INT_s falls.

## Test plan
- Reset release -> RSTCAPT high exactly 2 cycles, CE_N=1, SCLK=0 throughout; then with INT=0, IDLE and BUSY=0.
- Behavioural timestamper model holding 4'b1010 raises INT, TS_READY=1.
  - Expect CE_N low 18 cycles with 4 SCLK pulses of period 4, TS_DATA=4'hA, TS_VALID=1 for 1 cycle.
  - Expect RSTCAPT 2 cycles and the model drops INT.
- TS_READY=0, two back-to-back captures 4'h3 then 4'hC.
  - Expect the second read not to start (CE_N stays 1, INT stays high) until TS_READY=1 consumes 4'h3.
  - Then expect 4'hC to be delivered.
- TS_READY tied 1, captures 4'hF, 4'h0, 4'h5 -> three words in order, no SCLK glitches, no extra RSTCAPT pulses.
- RST asserted after the 2nd SCLK rise of a read.
  - Expect outputs to reset asynchronously: CE_N=1, SCLK=0, TS_VALID=0, TS_DATA=0.
  - Expect the INIT RSTCAPT pulse, then a clean full read of the next captured word, 4'h7.
- WIDTH=8, SCLK_DIV=1, word 8'h96 -> 8 SCLK pulses of period 2, CE_N low 17 cycles, TS_DATA=8'h96.
